// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic lamp monitor: phase numbers,
// lamp patterns {R1,Y1,G1,R2,Y2,G2}, fault codes and FSM states.
package traffic_pkg;

    localparam logic [1:0] PH_G1R2 = 2'd0;
    localparam logic [1:0] PH_Y1R2 = 2'd1;
    localparam logic [1:0] PH_R1G2 = 2'd2;
    localparam logic [1:0] PH_R1Y2 = 2'd3;

    localparam logic [5:0] LAMP_P0   = 6'b001100;
    localparam logic [5:0] LAMP_P1   = 6'b010100;
    localparam logic [5:0] LAMP_P2   = 6'b100001;
    localparam logic [5:0] LAMP_P3   = 6'b100010;
    localparam logic [5:0] LAMP_DARK = 6'b000000;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ILLEGAL = 2'd1;
    localparam logic [1:0] FLT_SEQ     = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

endpackage

// File: rtl/lamp_decode.sv
// Combinational lamp pattern decoder.
// Ports: lamp[5:0] in; is_dark, is_illegal, phase[1:0] out.
module lamp_decode
    import traffic_pkg::*;
(
    input  logic [5:0] lamp,
    output logic       is_dark,
    output logic       is_illegal,
    output logic [1:0] phase
);

    always_comb begin
        is_dark    = 1'b0;
        is_illegal = 1'b0;
        phase      = PH_G1R2;
        case (lamp)
            LAMP_P0:   phase = PH_G1R2;
            LAMP_P1:   phase = PH_Y1R2;
            LAMP_P2:   phase = PH_R1G2;
            LAMP_P3:   phase = PH_R1Y2;
            LAMP_DARK: is_dark = 1'b1;
            default:   is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Passive checker on a two-way traffic light: measures phase durations,
// reports completed cycles and latches the first fault until cleared.
// Ports: clk, rst_n, R1..G2 lamps, clr_fault in; phase, dur_g1/y1/g2/y2,
// cycle_valid, fault, fault_code out.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned          CNT_W   = 8,
    parameter logic [CNT_W-1:0]     TIMEOUT = 8'd250
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             R1,
    input  logic             Y1,
    input  logic             G1,
    input  logic             R2,
    input  logic             Y2,
    input  logic             G2,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dur_g1,
    output logic [CNT_W-1:0] dur_y1,
    output logic [CNT_W-1:0] dur_g2,
    output logic [CNT_W-1:0] dur_y2,
    output logic             cycle_valid,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [5:0]       lamp_q;
    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shd_q [4];
    logic [CNT_W-1:0] shd_d [4];
    logic [CNT_W-1:0] dur_q [4];
    logic [CNT_W-1:0] dur_d [4];
    logic [3:0]       cap_q, cap_d;
    logic             armed_q, armed_d;
    logic             cv_q, cv_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic             is_dark;
    logic             is_illegal;
    logic [1:0]       dec_phase;
    logic [1:0]       succ;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       new_code;

    lamp_decode u_dec (
        .lamp       (lamp_q),
        .is_dark    (is_dark),
        .is_illegal (is_illegal),
        .phase      (dec_phase)
    );

    assign succ    = phase_q + 2'd1;
    assign cnt_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        count_d  = count_q;
        shd_d    = shd_q;
        dur_d    = dur_q;
        cap_d    = cap_q;
        armed_d  = armed_q;
        cv_d     = 1'b0;
        fault_d  = fault_q;
        code_d   = code_q;
        new_code = FLT_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (is_illegal) begin
                    new_code = FLT_ILLEGAL;
                end else if (!is_dark) begin
                    state_d = ST_RUN;
                    phase_d = dec_phase;
                    count_d = CNT_ONE;
                    cap_d   = 4'b0000;
                    armed_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (is_illegal) begin
                    new_code = FLT_ILLEGAL;
                end else if (is_dark) begin
                    new_code = FLT_SEQ;
                end else if (dec_phase == phase_q) begin
                    if (cnt_inc == TIMEOUT) begin
                        new_code = FLT_TIMEOUT;
                    end else begin
                        count_d = cnt_inc;
                    end
                end else if (dec_phase == succ) begin
                    shd_d[phase_q] = count_q;
                    cap_d[phase_q] = 1'b1;
                    count_d        = CNT_ONE;
                    phase_d        = succ;
                    // Wrap to phase 0 closes a cycle; the first wrap after
                    // entry only arms, since the entry phase was partial.
                    if (phase_q == PH_R1Y2) begin
                        if (armed_q && (&cap_q[2:0])) begin
                            dur_d = shd_d;
                            cv_d  = 1'b1;
                        end
                        armed_d = 1'b1;
                        cap_d   = 4'b0000;
                    end
                end else begin
                    new_code = FLT_SEQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (new_code != FLT_NONE) begin
            state_d = ST_IDLE;
            count_d = '0;
            cap_d   = 4'b0000;
            armed_d = 1'b0;
        end

        // A fresh fault beats a coincident clear; otherwise the first
        // fault since the last clear is kept.
        if ((new_code != FLT_NONE) && (!fault_q || clr_fault)) begin
            fault_d = 1'b1;
            code_d  = new_code;
        end else if (clr_fault) begin
            fault_d = 1'b0;
            code_d  = FLT_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_q  <= LAMP_DARK;
            state_q <= ST_IDLE;
            phase_q <= PH_G1R2;
            count_q <= '0;
            for (int i = 0; i < 4; i++) begin
                shd_q[i] <= '0;
                dur_q[i] <= '0;
            end
            cap_q   <= 4'b0000;
            armed_q <= 1'b0;
            cv_q    <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FLT_NONE;
        end else begin
            lamp_q  <= {R1, Y1, G1, R2, Y2, G2};
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            shd_q   <= shd_d;
            dur_q   <= dur_d;
            cap_q   <= cap_d;
            armed_q <= armed_d;
            cv_q    <= cv_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign phase       = phase_q;
    assign dur_g1      = dur_q[0];
    assign dur_y1      = dur_q[1];
    assign dur_g2      = dur_q[2];
    assign dur_y2      = dur_q[3];
    assign cycle_valid = cv_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor (TIMEOUT set to 10).
// Inputs change on the falling edge; outputs are read there as well.
module tb_traffic_lamp_monitor;

    localparam logic [5:0] P0   = 6'b001100;
    localparam logic [5:0] P1   = 6'b010100;
    localparam logic [5:0] P2   = 6'b100001;
    localparam logic [5:0] P3   = 6'b100010;
    localparam logic [5:0] DARK = 6'b000000;
    localparam logic [5:0] BAD  = 6'b001001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       R1 = 0, Y1 = 0, G1 = 0, R2 = 0, Y2 = 0, G2 = 0;
    logic       clr_fault = 1'b0;
    logic [1:0] phase;
    logic [7:0] dur_g1, dur_y1, dur_g2, dur_y2;
    logic       cycle_valid;
    logic       fault;
    logic [1:0] fault_code;

    int checks = 0;
    int failures = 0;
    int cv_count = 0;

    traffic_lamp_monitor #(
        .CNT_W   (8),
        .TIMEOUT (8'd10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .R1          (R1),
        .Y1          (Y1),
        .G1          (G1),
        .R2          (R2),
        .Y2          (Y2),
        .G2          (G2),
        .clr_fault   (clr_fault),
        .phase       (phase),
        .dur_g1      (dur_g1),
        .dur_y1      (dur_y1),
        .dur_g2      (dur_g2),
        .dur_y2      (dur_y2),
        .cycle_valid (cycle_valid),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (cycle_valid === 1'b1) cv_count++;
    end

    task automatic hold(input logic [5:0] p, input int n);
        {R1, Y1, G1, R2, Y2, G2} = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_cycle(input int a, input int b,
                             input int c, input int d);
        hold(P0, a);
        hold(P1, b);
        hold(P2, c);
        hold(P3, d);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clr_fault = 1'b0;
        {R1, Y1, G1, R2, Y2, G2} = DARK;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cv_count = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({phase, cycle_valid, fault, fault_code} !== 6'b0 ||
            {dur_g1, dur_y1, dur_g2, dur_y2} !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got ph=%0d cv=%0b f=%0b c=%0d dur=%h",
                     phase, cycle_valid, fault, fault_code,
                     {dur_g1, dur_y1, dur_g2, dur_y2});
        end
        do_reset();
    endtask

    task automatic test_nominal;
        do_reset();
        hold(DARK, 3);
        run_cycle(5, 2, 5, 2);
        run_cycle(5, 2, 5, 2);
        hold(P0, 1);
        checks++;
        if (cv_count !== 0) begin
            failures++;
            $display("FAIL nominal_early got %0d pulses want 0", cv_count);
        end
        hold(P0, 1);
        checks++;
        if (cv_count !== 1) begin
            failures++;
            $display("FAIL nominal_pulse got %0d pulses want 1", cv_count);
        end
        checks++;
        if ({dur_g1, dur_y1, dur_g2, dur_y2} !== {8'd5, 8'd2, 8'd5, 8'd2}) begin
            failures++;
            $display("FAIL nominal_dur got %0d %0d %0d %0d want 5 2 5 2",
                     dur_g1, dur_y1, dur_g2, dur_y2);
        end
        hold(P0, 1);
        checks++;
        if (cycle_valid !== 1'b0 || fault !== 1'b0 || phase !== 2'd0) begin
            failures++;
            $display("FAIL nominal_after got cv=%0b f=%0b ph=%0d want 0 0 0",
                     cycle_valid, fault, phase);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        hold(P0, 3);
        hold(BAD, 1);
        checks++;
        if (fault !== 1'b0) begin
            failures++;
            $display("FAIL illegal_early got fault=%0b want 0", fault);
        end
        hold(DARK, 1);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd1) begin
            failures++;
            $display("FAIL illegal_code got f=%0b c=%0d want 1 1",
                     fault, fault_code);
        end
        hold(P2, 3);
        checks++;
        if (phase !== 2'd2 || fault_code !== 2'd1) begin
            failures++;
            $display("FAIL illegal_idle got ph=%0d c=%0d want 2 1",
                     phase, fault_code);
        end
    endtask

    task automatic test_sequence;
        do_reset();
        hold(P0, 4);
        hold(P2, 2);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd2) begin
            failures++;
            $display("FAIL seq_code got f=%0b c=%0d want 1 2",
                     fault, fault_code);
        end
        hold(BAD, 2);
        hold(DARK, 1);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd2) begin
            failures++;
            $display("FAIL seq_sticky got f=%0b c=%0d want 1 2",
                     fault, fault_code);
        end
    endtask

    task automatic test_timeout_clear;
        do_reset();
        hold(P0, 2);
        hold(P1, 10);
        checks++;
        if (fault !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got fault=%0b want 0", fault);
        end
        hold(DARK, 1);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd3) begin
            failures++;
            $display("FAIL timeout_code got f=%0b c=%0d want 1 3",
                     fault, fault_code);
        end
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'd0) begin
            failures++;
            $display("FAIL clear got f=%0b c=%0d want 0 0", fault, fault_code);
        end
        hold(P0, 2);
        hold(P2, 1);
        hold(DARK, 1);
        checks++;
        if (fault_code !== 2'd2) begin
            failures++;
            $display("FAIL clear_seq got c=%0d want 2", fault_code);
        end
        hold(BAD, 1);
        {R1, Y1, G1, R2, Y2, G2} = DARK;
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd1) begin
            failures++;
            $display("FAIL clear_vs_new got f=%0b c=%0d want 1 1",
                     fault, fault_code);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        hold(DARK, 1);
        run_cycle(3, 2, 2, 2);
        run_cycle(3, 2, 2, 2);
        hold(P0, 3);
        checks++;
        if (cv_count !== 1 || dur_g1 !== 8'd3) begin
            failures++;
            $display("FAIL mid_pre got pulses=%0d g1=%0d want 1 3",
                     cv_count, dur_g1);
        end
        hold(P1, 2);
        hold(P2, 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({phase, cycle_valid, fault, fault_code} !== 6'b0 ||
            {dur_g1, dur_y1, dur_g2, dur_y2} !== 32'h0) begin
            failures++;
            $display("FAIL mid_async got ph=%0d dur=%h",
                     phase, {dur_g1, dur_y1, dur_g2, dur_y2});
        end
        {R1, Y1, G1, R2, Y2, G2} = DARK;
        @(negedge clk);
        rst_n = 1'b1;
        cv_count = 0;
        run_cycle(4, 2, 3, 4);
        hold(P0, 4);
        checks++;
        if (cv_count !== 0) begin
            failures++;
            $display("FAIL mid_first got %0d pulses want 0", cv_count);
        end
        hold(P1, 2);
        hold(P2, 3);
        hold(P3, 4);
        hold(P0, 3);
        checks++;
        if (cv_count !== 1 ||
            {dur_g1, dur_y1, dur_g2, dur_y2} !== {8'd4, 8'd2, 8'd3, 8'd4}) begin
            failures++;
            $display("FAIL mid_second got pulses=%0d dur=%0d %0d %0d %0d want 1 4 2 3 4",
                     cv_count, dur_g1, dur_y1, dur_g2, dur_y2);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(1, 1, 1, 1);
        hold(P0, 3);
        checks++;
        if (cv_count !== 2 || fault !== 1'b0) begin
            failures++;
            $display("FAIL single_pulses got pulses=%0d f=%0b want 2 0",
                     cv_count, fault);
        end
        checks++;
        if ({dur_g1, dur_y1, dur_g2, dur_y2} !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
            failures++;
            $display("FAIL single_dur got %0d %0d %0d %0d want 1 1 1 1",
                     dur_g1, dur_y1, dur_g2, dur_y2);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_illegal();
        test_sequence();
        test_timeout_clear();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
